// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART front end: status/data registers, a TX holding register
// drained by a handshake FSM, and a small RX FIFO filled from the receiver.
module uart_mmio_ctrl #(
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic        req_re,
    output logic [31:0] req_rdata,
    output logic        req_stall,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_clear
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [31:0] ADDR_STATE = 32'hBFD003FC;
    localparam logic [31:0] ADDR_DATA  = 32'hBFD003F8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
    typedef enum logic {RX_IDLE, RX_CLEAR} rx_state_t;

    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;

    logic [7:0]    hold;
    logic          hold_valid;
    logic [7:0]    fifo [RX_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic hit_state, hit_data, wr_accept, pop_now, push_now, fifo_empty;

    assign hit_state  = (req_addr == ADDR_STATE);
    assign hit_data   = (req_addr == ADDR_DATA);
    assign fifo_empty = (count == '0);
    assign wr_accept  = req_we & hit_data & ~hold_valid;
    assign req_stall  = req_we & hit_data & hold_valid;
    assign pop_now    = req_re & hit_data & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_now   = (rx_state == RX_IDLE) & rx_ready &
                        ((count < (PW+1)'(RX_DEPTH)) | pop_now);

    always_comb begin
        req_rdata = '0;
        if (hit_state)
            req_rdata = {30'b0, ~fifo_empty, ~hold_valid};
        else if (hit_data && !fifo_empty)
            req_rdata = {24'b0, fifo[head]};
    end

    // TX FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:      if (hold_valid || wr_accept) tx_next = TX_START;
            TX_START:     tx_next = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (tx_busy) tx_next = TX_WAIT_DONE;
            TX_WAIT_DONE: if (!tx_busy) tx_next = TX_IDLE;
            default:      tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_start = (tx_state == TX_START);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            tx_data    <= '0;
        end else begin
            if (tx_state == TX_START) begin
                tx_data    <= hold;
                hold_valid <= 1'b0;
            end
            if (wr_accept) begin
                hold       <= req_wdata[7:0];
                hold_valid <= 1'b1;
            end
        end
    end

    // RX FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = RX_IDLE;
        if (rx_state == RX_IDLE && push_now) rx_next = RX_CLEAR;
    end

    always_comb begin
        rx_clear = (rx_state == RX_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (push_now) fifo[tail] <= rx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_now) tail <= tail + PW'(1);
            if (pop_now)  head <= head + PW'(1);
            case ({push_now, pop_now})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
